// File: rtl/rr_grant_sched_if.sv
// rtl/rr_grant_sched_if.sv - request/grant bundle between requesters and rr_grant_sched
interface rr_grant_sched_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           timeout;
  logic [7:0]     err_cnt;

  modport master (
    output req, done,
    input  gnt, gnt_valid, gnt_id, timeout, err_cnt
  );

  modport slave (
    input  req, done,
    output gnt, gnt_valid, gnt_id, timeout, err_cnt
  );
endinterface

// File: rtl/rr_grant_sched.sv
// rtl/rr_grant_sched.sv - round-robin grant scheduler with hold watchdog
module rr_grant_sched #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_grant_sched_if.slave  bus
);
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           holder_done;
  logic           holder_req;
  logic           viol;

  // Search starts one past the last holder so every requester gets its turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(ptr_q) + k) % N);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // gnt_q is one-hot in GRANT, so masking picks out the holder's bits.
  assign holder_done = |(bus.done & gnt_q);
  assign holder_req  = |(bus.req & gnt_q);

  always_comb begin
    viol = 1'b0;
    if (state_q == IDLE) begin
      viol = |bus.done;
    end else begin
      viol = (|(bus.done & ~gnt_q)) || (!holder_done && !holder_req);
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          gnt_d      = {{(N-1){1'b0}}, 1'b1} << win_id;
          gnt_id_d   = win_id;
          ptr_d      = win_id;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (holder_done || !holder_req || hold_cnt_q == HW'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          timeout_d = !holder_done && holder_req;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (viol && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= IDW'(N - 1);
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;
  assign bus.err_cnt   = err_cnt_q;

  // Invariant checks on our own outputs; report only.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(gnt_q)) else $error("gnt not onehot0: %b", gnt_q);
      assert (bus.gnt_valid == |gnt_q) else $error("gnt_valid inconsistent");
      assert (!bus.gnt_valid || gnt_q[gnt_id_q]) else $error("gnt_id does not match gnt");
      assert (!timeout_q || !bus.gnt_valid) else $error("timeout while granted");
    end
  end
endmodule

// File: tb/tb_rr_grant_sched.sv
// tb/tb_rr_grant_sched.sv - directed self-checking bench for rr_grant_sched
module tb_rr_grant_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  rr_grant_sched_if #(.N(4)) bus ();

  rr_grant_sched #(.N(4), .MAX_HOLD(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // 1: reset state and a single grant/release
    do_reset();
    check("rst_gnt", bus.gnt, 0);
    check("rst_valid", bus.gnt_valid, 0);
    check("rst_id", bus.gnt_id, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_err", bus.err_cnt, 0);
    bus.req = 4'b0001;
    tick();
    check("t1_gnt", bus.gnt, 4'b0001);
    check("t1_id", bus.gnt_id, 0);
    check("t1_valid", bus.gnt_valid, 1);
    tick();
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    bus.req  = '0;
    check("t1_rel_gnt", bus.gnt, 0);
    check("t1_rel_err", bus.err_cnt, 0);
    check("t1_rel_to", bus.timeout, 0);

    // 2: fairness with all requesting, two-cycle grants and one-cycle gaps
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_gnt", bus.gnt, 32'(1) << order[i]);
      check("t2_id", bus.gnt_id, order[i]);
      tick();
      check("t2_hold", bus.gnt, 32'(1) << order[i]);
      bus.done = bus.gnt;
      tick();
      bus.done = '0;
      check("t2_gap", bus.gnt, 0);
    end
    bus.req = '0;
    tick();

    // 3: watchdog revokes after 16 cycles, then re-grants
    do_reset();
    bus.req = 4'b0100;
    tick();
    check("t3_gnt", bus.gnt, 4'b0100);
    cnt = 1;
    for (int i = 0; i < 40 && bus.gnt_valid; i++) begin
      tick();
      if (bus.gnt_valid) cnt++;
    end
    check("t3_hold_len", cnt, 16);
    check("t3_to", bus.timeout, 1);
    check("t3_to_gnt", bus.gnt, 0);
    tick();
    check("t3_regnt", bus.gnt, 4'b0100);
    check("t3_to_clr", bus.timeout, 0);
    check("t3_err", bus.err_cnt, 0);
    bus.req  = '0;
    bus.done = 4'b0100;
    tick();
    bus.done = '0;
    check("t3_rel", bus.gnt, 0);
    check("t3_err2", bus.err_cnt, 0);

    // 4: foreign done counts; done on the last hold cycle beats the watchdog
    do_reset();
    bus.req = 4'b0010;
    tick();
    check("t4_gnt", bus.gnt, 4'b0010);
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    check("t4_err", bus.err_cnt, 1);
    check("t4_keep", bus.gnt, 4'b0010);
    for (int i = 0; i < 14; i++) tick();
    check("t4_last", bus.gnt, 4'b0010);
    bus.done = 4'b0010;
    tick();
    bus.done = '0;
    bus.req  = '0;
    check("t4_rel", bus.gnt, 0);
    check("t4_to", bus.timeout, 0);
    check("t4_err2", bus.err_cnt, 1);

    // 5: holder drops request, then saturate the violation counter
    do_reset();
    bus.req = 4'b1000;
    tick();
    check("t5_id", bus.gnt_id, 3);
    bus.req = '0;
    tick();
    check("t5_drop_gnt", bus.gnt, 0);
    check("t5_drop_err", bus.err_cnt, 1);
    check("t5_drop_to", bus.timeout, 0);
    bus.done = 4'b0001;
    for (int i = 0; i < 253; i++) tick();
    check("t5_err254", bus.err_cnt, 254);
    for (int i = 0; i < 47; i++) tick();
    bus.done = '0;
    check("t5_sat", bus.err_cnt, 255);

    // 6: reset in the middle of a grant
    do_reset();
    bus.req = 4'b0100;
    tick();
    check("t6_gnt", bus.gnt, 4'b0100);
    bus.req = 4'b1111;
    tick();
    check("t6_nopreempt", bus.gnt, 4'b0100);
    rst_n = 1'b0;
    tick();
    check("t6_rst_gnt", bus.gnt, 0);
    check("t6_rst_valid", bus.gnt_valid, 0);
    check("t6_rst_id", bus.gnt_id, 0);
    check("t6_rst_to", bus.timeout, 0);
    rst_n = 1'b1;
    tick();
    check("t6_first", bus.gnt, 4'b0001);
    check("t6_first_id", bus.gnt_id, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
